// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch path.
//   XLEN / ILEN    : address and instruction widths
//   INSTR_BYTES    : byte step between sequential fetches
//   fetch_state_e  : request-tracking FSM states of the fetch unit
//   fetch_entry_t  : one buffered {pc, instr} pair handed to decode
//   align_pc       : force an address onto a word boundary
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,   // free to send a request
        WAIT  = 2'd1,   // request outstanding, response will be kept
        KILL  = 2'd2    // request outstanding, response will be dropped
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO of fetch_entry_t between memory and decode.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : remove the head entry
//   flush      : discard all entries (takes priority over push/pop)
//   full/empty : occupancy flags
//   count      : number of valid entries (0..DEPTH)
//   head       : oldest entry (meaningful only when !empty)
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output fetch_entry_t               head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so push is allowed when full if popping.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;   // DEPTH is a power of 2: natural wrap
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one memory request at a time,
// buffers returned instructions for decode and restarts on redirects.
//   clk, rst        : clock, asynchronous active-high reset
//   redirect_valid  : restart fetch at redirect_pc (bits [1:0] ignored)
//   redirect_pc     : new fetch address
//   imem_req_*      : request channel to instruction memory (valid/ready/addr)
//   imem_rsp_*      : in-order response channel (valid/data), no backpressure
//   if_valid/if_pc/if_instr/if_ready : buffer head toward decode
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e     state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  req_pc;
    logic             live;
    logic             accept;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    fetch_entry_t     push_data;
    fetch_entry_t     head;

    // Requests are only issued from ISSUE, where nothing is outstanding, so
    // checking the buffer count alone keeps count + outstanding <= DEPTH.
    // 'live' holds the request low in the first cycle out of reset.
    assign imem_req_valid = live && (state == ISSUE) && (count < CW'(DEPTH)) && !redirect_valid;
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response coinciding with a redirect belongs to the old path.
    assign push      = (state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop       = if_valid && if_ready;
    assign push_data = '{pc: req_pc, instr: imem_rsp_data};

    assign if_valid = !empty;
    assign if_pc    = head.pc;
    assign if_instr = head.instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ISSUE;
            pc    <= RESET_PC;
            live  <= 1'b0;
        end else begin
            live <= 1'b1;
            case (state)
                ISSUE: begin
                    if (accept) begin
                        pc    <= pc + XLEN'(INSTR_BYTES);   // wraps modulo 2^32
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= ISSUE;
                    end else if (redirect_valid) begin
                        state <= KILL;
                    end
                end
                KILL: begin
                    if (imem_rsp_valid) begin
                        state <= ISSUE;
                    end
                end
                default: state <= ISSUE;
            endcase
            // Redirect overrides any sequential PC update; no accept can
            // coincide with it because the request is masked that cycle.
            if (redirect_valid) begin
                pc <= align_pc(redirect_pc);
            end
        end
    end

    // Address of the outstanding request, tagged onto its response.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_pc <= pc;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: instruction memory model with programmable
// latency, decode-side monitor, and one task per scenario.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    int errors = 0;
    int checks = 0;

    // memory model controls and state
    int          lat = 1;
    bit          mem_en = 1'b1;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;
    logic        model_v = 1'b0;
    logic [31:0] model_d = '0;
    logic        inj_v = 1'b0;
    logic [31:0] inj_d = '0;

    logic [31:0] acc_log [$];
    logic [31:0] pop_pc  [$];
    logic [31:0] pop_in  [$];

    int   pb;
    int   ab;
    logic rv_redir;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rsp_valid = mem_en ? model_v : inj_v;
    assign imem_rsp_data  = mem_en ? model_d : inj_d;

    // Inputs change #1 after posedge; everything is sampled on negedge, where
    // a visible valid&ready means the handshake happens at the next posedge.
    always @(negedge clk) begin
        model_v = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    model_v = 1'b1;
                    model_d = instr_of(pend_addr);
                    pend    = 1'b0;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                acc_log.push_back(imem_req_addr);
                pend      = 1'b1;
                pend_addr = imem_req_addr;
                cnt       = lat;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if_valid && if_ready) begin
            pop_pc.push_back(if_pc);
            pop_in.push_back(if_instr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle redirect pulse; records queue bases after the redirect-cycle
    // handshake and samples imem_req_valid inside the redirect cycle.
    task automatic redirect_to(input logic [31:0] addr);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = addr;
        @(negedge clk);
        #1;
        rv_redir = imem_req_valid;
        pb = pop_pc.size();
        ab = acc_log.size();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%0b exp=0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr got=%h exp=00000000", imem_req_addr); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got=%0b exp=0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc got=%h exp=00000000", if_pc); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr got=%h exp=00000000", if_instr); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
        for (int i = 0; i < 80 && pop_pc.size() < 4; i++) begin @(negedge clk); #1; end
        checks++; if (pop_pc.size() < 4) begin errors++; $display("FAIL stream_timeout got=%0d pops exp=4", pop_pc.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (pop_pc[i] !== exp_pc[i]) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, pop_pc[i], exp_pc[i]); end
            checks++; if (pop_in[i] !== instr_of(exp_pc[i])) begin errors++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, pop_in[i], instr_of(exp_pc[i])); end
        end
    endtask

    task automatic test_stall();
        int          base;
        logic [31:0] last;
        step();
        if_ready = 1'b0;
        base = pop_pc.size();
        last = pop_pc[base-1];
        repeat (10) step();
        @(negedge clk); #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid got=%0b exp=0", imem_req_valid); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_if_valid got=%0b exp=1", if_valid); end
        checks++; if (if_pc !== last + 32'd4) begin errors++; $display("FAIL stall_head_pc got=%h exp=%h", if_pc, last + 32'd4); end
        checks++; if (pop_pc.size() != base) begin errors++; $display("FAIL stall_no_pop got=%0d exp=%0d", pop_pc.size(), base); end
        step();
        if_ready = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++; if (pop_pc.size() - base != 2) begin errors++; $display("FAIL stall_buffered got=%0d exp=2", pop_pc.size() - base); end
        @(negedge clk); #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got=%0b exp=0", if_valid); end
        for (int i = 0; i < 80 && pop_pc.size() < base + 4; i++) begin @(negedge clk); #1; end
        for (int i = 0; i < 4; i++) begin
            checks++; if (pop_pc[base+i] !== last + 32'(4*(i+1))) begin errors++; $display("FAIL stall_order[%0d] got=%h exp=%h", i, pop_pc[base+i], last + 32'(4*(i+1))); end
        end
    endtask

    task automatic test_redirect_outstanding();
        bit found = 1'b0;
        step();
        lat = 3;
        redirect_to(32'h0);
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk); #1;
            for (int k = ab; k < acc_log.size(); k++) if (acc_log[k] == 32'h8) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL kill_setup got=no accept of 00000008 exp=accept"); end
        redirect_to(32'h100);
        checks++; if (rv_redir !== 1'b0) begin errors++; $display("FAIL kill_req_in_redirect got=%0b exp=0", rv_redir); end
        for (int i = 0; i < 80 && (acc_log.size() <= ab || pop_pc.size() < pb + 2); i++) begin @(negedge clk); #1; end
        checks++; if (acc_log[ab] !== 32'h100) begin errors++; $display("FAIL kill_first_addr got=%h exp=00000100", acc_log[ab]); end
        checks++; if (pop_pc[pb] !== 32'h100) begin errors++; $display("FAIL kill_first_pc got=%h exp=00000100", pop_pc[pb]); end
        checks++; if (pop_in[pb] !== instr_of(32'h100)) begin errors++; $display("FAIL kill_first_instr got=%h exp=%h", pop_in[pb], instr_of(32'h100)); end
        checks++; if (pop_pc[pb+1] !== 32'h104) begin errors++; $display("FAIL kill_second_pc got=%h exp=00000104", pop_pc[pb+1]); end
    endtask

    task automatic test_redirect_unaligned();
        step();
        lat = 1;
        redirect_to(32'h203);
        for (int i = 0; i < 80 && (acc_log.size() <= ab || pop_pc.size() < pb + 2); i++) begin @(negedge clk); #1; end
        checks++; if (acc_log[ab] !== 32'h200) begin errors++; $display("FAIL align_addr got=%h exp=00000200", acc_log[ab]); end
        checks++; if (pop_pc[pb] !== 32'h200) begin errors++; $display("FAIL align_pc got=%h exp=00000200", pop_pc[pb]); end
        checks++; if (pop_pc[pb+1] !== 32'h204) begin errors++; $display("FAIL align_next_pc got=%h exp=00000204", pop_pc[pb+1]); end
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFC);
        for (int i = 0; i < 80 && (acc_log.size() < ab + 2 || pop_pc.size() < pb + 2); i++) begin @(negedge clk); #1; end
        checks++; if (acc_log[ab] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", acc_log[ab]); end
        checks++; if (acc_log[ab+1] !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got=%h exp=00000000", acc_log[ab+1]); end
        checks++; if (pop_pc[pb] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got=%h exp=fffffffc", pop_pc[pb]); end
        checks++; if (pop_pc[pb+1] !== 32'h0) begin errors++; $display("FAIL wrap_pc1 got=%h exp=00000000", pop_pc[pb+1]); end
        checks++; if (pop_in[pb+1] !== instr_of(32'h0)) begin errors++; $display("FAIL wrap_instr1 got=%h exp=%h", pop_in[pb+1], instr_of(32'h0)); end
    endtask

    task automatic test_reset_mid_request();
        step();
        lat = 6;
        redirect_to(32'h40);
        for (int i = 0; i < 40 && acc_log.size() <= ab; i++) begin @(negedge clk); #1; end
        checks++; if (acc_log[ab] !== 32'h40) begin errors++; $display("FAIL rstmid_setup got=%h exp=00000040", acc_log[ab]); end
        step();
        rst    = 1'b1;
        mem_en = 1'b0;
        inj_v  = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_req_valid got=%0b exp=0", imem_req_valid); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rstmid_if_valid got=%0b exp=0", if_valid); end
        repeat (2) step();
        rst   = 1'b0;
        inj_v = 1'b1;
        inj_d = 32'hBAD0_BAD0;
        pb = pop_pc.size();
        ab = acc_log.size();
        step();
        inj_v  = 1'b0;
        mem_en = 1'b1;
        @(negedge clk); #1;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rstmid_late_rsp got if_valid=%0b exp=0", if_valid); end
        for (int i = 0; i < 80 && (acc_log.size() <= ab || pop_pc.size() <= pb); i++) begin @(negedge clk); #1; end
        checks++; if (acc_log[ab] !== 32'h0) begin errors++; $display("FAIL rstmid_first_addr got=%h exp=00000000", acc_log[ab]); end
        checks++; if (pop_pc[pb] !== 32'h0) begin errors++; $display("FAIL rstmid_first_pc got=%h exp=00000000", pop_pc[pb]); end
        checks++; if (pop_in[pb] !== instr_of(32'h0)) begin errors++; $display("FAIL rstmid_first_instr got=%h exp=%h", pop_in[pb], instr_of(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_outstanding();
        test_redirect_unaligned();
        test_wrap();
        test_reset_mid_request();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
